// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: requester identity and FSM state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dmem_arb_pkg;

  // Which requester was granted most recently; drives round-robin priority.
  typedef enum logic {OWN_CORE, OWN_DMA} owner_e;

  // ARB: plain round-robin. LOCK: DMA holds the memory for a bounded burst.
  typedef enum logic {ST_ARB, ST_LOCK} arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core port, DMA port and DataMemory port around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req + payload until they see gnt.
// Ports: core_* / dma_* request side, mem_* single-port memory side.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants/responses/mem bus)
//   master : environment view (drives requests and mem_rdata)
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_lock;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker: grants the lone requester, or on a tie the one that did not win last.
// Latency: combinational, 0 cycles.
// Backpressure: none; losers simply see gnt=0 and keep requesting.
// Ports: req[0]=core, req[1]=dma; last_owner = previous winner; gnt one-hot or zero.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_owner,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | (last_owner == OWN_DMA));
  assign gnt[1] = req[1] & (~req[0] | (last_owner == OWN_CORE));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port DataMemory between core and DMA, with bounded DMA lock bursts.
// Latency: grant and memory bus combinational (0 cycles); read data/rvalid registered (1 cycle).
// Backpressure: losing requester sees gnt=0 and holds; one access per cycle, core waits at most MAX_BURST locked beats.
// Ports: clk, rst (sync, active-high), bus (slave modport: core/dma request ports + mem port).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input logic            clk,
  input logic            rst,
  dmem_arbiter_if.slave  bus
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_nxt;
  owner_e           last_owner;

  logic [1:0] rr_gnt;
  logic       lock_beat;
  logic       core_gnt;
  logic       dma_gnt;

  rr_arb2 u_rr (
    .req        ({bus.dma_req, bus.core_req}),
    .last_owner (last_owner),
    .gnt        (rr_gnt)
  );

  // A locked beat is only honoured while DMA keeps both req and lock up;
  // otherwise the cycle falls back to ordinary round-robin.
  assign lock_beat = (state == ST_LOCK) && bus.dma_req && bus.dma_lock;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ARB;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // Next-state logic. Any path not listed returns to ARB with a cleared count,
  // including the cycle where the core breaks a saturated burst.
  always_comb begin
    state_nxt = ST_ARB;
    beat_nxt  = '0;
    if (lock_beat) begin
      if (dma_gnt) begin
        state_nxt = ST_LOCK;
        beat_nxt  = (beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + 1'b1;
      end
    end else if (dma_gnt && bus.dma_lock) begin
      state_nxt = ST_LOCK;
      beat_nxt  = CNT_W'(1);
    end
  end

  // Output logic: grants and the memory bus mux
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (lock_beat) begin
      if ((beat_cnt == CNT_MAX) && bus.core_req) core_gnt = 1'b1;
      else                                       dma_gnt  = 1'b1;
    end else begin
      core_gnt = rr_gnt[0];
      dma_gnt  = rr_gnt[1];
    end

    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (core_gnt) begin
      bus.mem_addr  = bus.core_addr;
      bus.mem_we    = bus.core_we;
      bus.mem_wdata = bus.core_wdata;
    end else if (dma_gnt) begin
      bus.mem_addr  = bus.dma_addr;
      bus.mem_we    = bus.dma_we;
      bus.mem_wdata = bus.dma_wdata;
    end
  end

  assign bus.core_gnt = core_gnt;
  assign bus.dma_gnt  = dma_gnt;

  // Round-robin history and read responses
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner      <= OWN_DMA;
      bus.core_rvalid <= 1'b0;
      bus.dma_rvalid  <= 1'b0;
      bus.core_rdata  <= '0;
      bus.dma_rdata   <= '0;
    end else begin
      if (core_gnt)     last_owner <= OWN_CORE;
      else if (dma_gnt) last_owner <= OWN_DMA;

      bus.core_rvalid <= core_gnt & ~bus.core_we;
      bus.dma_rvalid  <= dma_gnt & ~bus.dma_we;
      if (core_gnt && !bus.core_we) bus.core_rdata <= bus.mem_rdata;
      if (dma_gnt && !bus.dma_we)   bus.dma_rdata  <= bus.mem_rdata;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the single-port data memory, shared between the processor core's load/store path and a DMA/loader port. Grants at most one access per cycle, registers read data back to the winning requester, and alternates round-robin under contention. Also supports a bounded DMA lock (burst) mode, so bulk transfers can run back-to-back without starving the core. Sits between the core's memory stage and the DataMemory instance.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MAX_BURST, 8, max consecutive locked DMA grants while core is waiting (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high, sampled on the rising edge of clk
- core_req  in  1  core access request
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core access performed this cycle
- core_rvalid  out  1  core read data valid (cycle after read grant)
- core_rdata  out  DATA_W  core read data
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  same meaning for DMA
- dma_lock  in  1  DMA requests to keep ownership for next beat
- dma_gnt, dma_rvalid, dma_rdata  out  1/1/DATA_W  same meaning for DMA
- mem_addr  out  ADDR_W  to DataMemory address
- mem_we  out  1  to DataMemory write enable
- mem_wdata  out  DATA_W  to DataMemory write data
- mem_rdata  in  DATA_W  from DataMemory (combinational read)

## Operation
- Grants are combinational from current requests and registered state; core_gnt and dma_gnt are never both 1.
- The memory bus is driven combinationally from the granted port. With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- A requester holds req and its payload until it sees gnt. The arbiter does not depend on this.
- Read grant (we=0): mem_rdata is captured into that port's rdata register; rvalid=1 the next cycle for exactly one cycle.
- Write grant: no rvalid. The write commits at the grant edge (DataMemory behaviour).
- rdata holds its last captured value when rvalid=0.
- Round-robin uses the last_owner register (CORE/DMA), updated on every grant.
  - Only one port requesting: it wins.
  - Both requesting in ARB state: the port that is not last_owner wins.
- FSM has two states, ARB and LOCK, plus a beat_cnt register of width $clog2(MAX_BURST+1).
  - ARB → LOCK: dma granted with dma_lock=1; beat_cnt←1.
  - In LOCK, DMA wins whenever dma_req & dma_lock, unless beat_cnt==MAX_BURST & core_req. In that case the core wins; next state ARB, beat_cnt←0.
  - In LOCK, each locked DMA grant increments beat_cnt, saturating at MAX_BURST. DMA keeps ownership at saturation while core_req=0.
  - In LOCK with dma_req=0 or dma_lock=0: that cycle is arbitrated by ARB rules; next state ARB, beat_cnt←0. If DMA is granted then with dma_lock=1, the ARB→LOCK rule applies instead.
- Reset values: state=ARB, beat_cnt=0, last_owner=DMA (core wins the first tie), core_rvalid=dma_rvalid=0, core_rdata=dma_rdata=0.
- The gnt/mem outputs follow combinationally from these reset values.

## Timing
- Grant latency is 0 cycles: gnt is asserted in the cycle req is seen, if that port wins.
- Read data latency is 1 cycle: rvalid/rdata are registered at the grant edge.
- Throughput is one access per cycle; back-to-back reads from the same port give rvalid on consecutive cycles.
- Under continuous contention without lock, grants alternate CORE, DMA, CORE, …
- Maximum core wait while DMA holds the lock: MAX_BURST cycles, counted from the first locked beat.
- rst asserted mid-operation:
  - A read granted in the rst cycle produces no rvalid.
  - Grants still follow the combinational rule in that cycle, but state is forced to its reset values at the edge.
  - A write performed in the rst cycle is the memory's concern; the arbiter makes no guarantee.

## Structure
- Package dmem_arb_pkg holds:
  - typedef enum logic {OWN_CORE, OWN_DMA} owner_e;
  - typedef enum logic {ST_ARB, ST_LOCK} arb_state_e;
- One sub-module, rr_arb2: a combinational 2-input round-robin picker (req[1:0], last_owner → gnt[1:0]), reused by the ARB path.
- Everything else (FSM, counter, response registers, bus mux) lives in dmem_arbiter.

## Test plan
- Reset, then core read of addr 0x10 while DMA idle (mem holds 0xDEADBEEF) → core_gnt=1 same cycle; core_rvalid=1 and core_rdata=0xDEADBEEF next cycle; dma outputs 0.
- Both request continuously for 6 cycles, no lock, after reset → grants CORE, DMA, CORE, DMA, CORE, DMA; mem_addr follows the winner each cycle.
- DMA writes 0xA5A5A5A5 to 0x40, then core reads 0x40 the next cycle → DMA gnt with mem_we=1; core read returns 0xA5A5A5A5 one cycle after its grant.
- MAX_BURST=8, dma_lock=1 with continuous dma_req, core_req raised with the first DMA beat → 8 consecutive dma_gnt, then core_gnt on the 9th cycle, state back to ARB.
- Locked DMA, dma_lock drops after 3 beats with core waiting → core granted on the next cycle (RR: last_owner=DMA); beat_cnt=0.
- rst asserted the same cycle a core read is granted → no core_rvalid the following cycle; all registered outputs 0; the first tie after release goes to the core.
